// File: rtl/window_buffer.sv
// Sliding window of the 8 most recent 5-channel frames feeding the convolution stage.
// Define WINDOW_BUFFER_DONE_HANDSHAKE_EN to release BUSY on an i_conv_done rising edge instead of a fixed count.
module window_buffer #(
  parameter int NUM_CH      = 5,
  parameter int NUM_FRAMES  = 8,
  parameter int STRIDE      = 1,
  parameter int CONV_CYCLES = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_clear,
  input  logic                                 i_valid,
  input  logic [15:0]                          i_sample,
  output logic                                 o_ready,
  output logic [NUM_CH*NUM_FRAMES-1:0][15:0]   o_data,
  output logic                                 o_start,
  input  logic                                 i_conv_done,
  output logic [3:0]                           o_frames
);
  localparam int DEPTH = NUM_CH * NUM_FRAMES;
  localparam int CW    = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_START, S_BUSY} state_t;

  state_t                     r_state, w_state_nxt;
  logic [NUM_CH-2:0][15:0]    r_stage;
  logic [CW-1:0]              r_ch;
  logic [3:0]                 r_hop, w_hop_nxt;
  logic [3:0]                 r_frames, w_frames_nxt;
  logic [DEPTH-1:0][15:0]     r_data;
  logic                       w_acc, w_frame_done, w_busy_exit;

  assign o_ready      = (r_state == S_FILL) || (r_state == S_RUN);
  assign o_start      = (r_state == S_START);
  assign o_frames     = r_frames;
  assign o_data       = r_data;
  assign w_acc        = i_valid && o_ready;
  assign w_frame_done = w_acc && (r_ch == CW'(NUM_CH-1));

`ifdef WINDOW_BUFFER_DONE_HANDSHAKE_EN
  localparam int conv_cycles_unused = CONV_CYCLES;
  logic r_done_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_done_d <= 1'b0;
    else          r_done_d <= i_conv_done;
  end

  // Only a fresh rising edge releases BUSY; a level left high is ignored.
  assign w_busy_exit = i_conv_done && !r_done_d;
`else
  localparam int BW = $clog2(CONV_CYCLES + 1);
  logic [BW-1:0] r_busy_cnt;
  logic          w_done_unused;

  assign w_done_unused = i_conv_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_busy_cnt <= '0;
    else if (r_state == S_BUSY) r_busy_cnt <= r_busy_cnt + 1'b1;
    else                        r_busy_cnt <= '0;
  end

  assign w_busy_exit = (r_busy_cnt == BW'(CONV_CYCLES-1));
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_hop_nxt    = r_hop;
    w_frames_nxt = r_frames;
    case (r_state)
      S_FILL, S_RUN: begin
        if (w_frame_done) begin
          if (r_frames != 4'(NUM_FRAMES)) w_frames_nxt = r_frames + 4'd1;
          if (r_frames == 4'(NUM_FRAMES-1)) begin
            w_state_nxt = S_START;
            w_hop_nxt   = '0;
          end else if (r_state == S_RUN) begin
            if (r_hop + 4'd1 == 4'(STRIDE)) begin
              w_hop_nxt   = '0;
              w_state_nxt = S_START;
            end else begin
              w_hop_nxt   = r_hop + 4'd1;
            end
          end
        end
      end
      S_START: w_state_nxt = S_BUSY;
      S_BUSY:  if (w_busy_exit) w_state_nxt = S_RUN;
      default: w_state_nxt = S_FILL;
    endcase
    if (i_clear) begin
      w_state_nxt  = S_FILL;
      w_hop_nxt    = '0;
      w_frames_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_FILL;
      r_hop    <= '0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hop    <= w_hop_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch   <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_ch   <= '0;
      r_data <= '0;
    end else if (w_frame_done) begin
      r_ch   <= '0;
      // Shift out the oldest frame; the last channel comes straight from the bus.
      r_data <= {i_sample, r_stage, r_data[DEPTH-1:NUM_CH]};
    end else if (w_acc) begin
      r_ch   <= r_ch + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH-1; c++) begin : g_stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          r_stage[c] <= '0;
      else if (i_clear)                      r_stage[c] <= '0;
      else if (w_acc && r_ch == CW'(c))      r_stage[c] <= i_sample;
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Randomized bench for window_buffer: two instances (STRIDE 1 and 3) on shared inputs,
// each compared every cycle against a frame-level behavioural model.
module tb_window_buffer;
  localparam int CC = 4;
`ifdef WINDOW_BUFFER_DONE_HANDSHAKE_EN
  localparam int LOW_EXP = 4;
`else
  localparam int LOW_EXP = 1 + CC;
`endif

  logic                 clk, rst_n, clr, vld, done;
  logic [15:0]          smp;
  logic                 rdy [2];
  logic                 start [2];
  logic [3:0]           frames [2];
  logic [39:0][15:0]    dat [2];

  window_buffer #(.NUM_CH(5), .NUM_FRAMES(8), .STRIDE(1), .CONV_CYCLES(CC)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(vld), .i_sample(smp),
    .o_ready(rdy[0]), .o_data(dat[0]), .o_start(start[0]), .i_conv_done(done),
    .o_frames(frames[0]));

  window_buffer #(.NUM_CH(5), .NUM_FRAMES(8), .STRIDE(3), .CONV_CYCLES(CC)) u_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(vld), .i_sample(smp),
    .o_ready(rdy[1]), .o_data(dat[1]), .o_start(start[1]), .i_conv_done(done),
    .o_frames(frames[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  int dstarts [2];

  // Model: mode 0 = accepting, 1 = start pulse, 2 = busy.
  int m_win [2][40];
  int m_stg [2][5];
  int m_ch [2], m_frames [2], m_hop [2], m_mode [2], m_busy [2], m_total [2];
  bit m_dprev [2];
  int m_stride [2] = '{1, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset(input int i);
    for (int k = 0; k < 40; k++) m_win[i][k] = 0;
    for (int k = 0; k < 5; k++)  m_stg[i][k] = 0;
    m_ch[i] = 0; m_frames[i] = 0; m_hop[i] = 0; m_mode[i] = 0;
    m_busy[i] = 0; m_total[i] = 0; m_dprev[i] = 1'b0;
  endtask

  task automatic m_step(input int i, input bit cl, input bit v, input logic [15:0] s, input bit d);
    if (cl) m_reset(i);
    else case (m_mode[i])
      0: if (v) begin
        if (m_ch[i] < 4) begin
          m_stg[i][m_ch[i]] = int'(s);
          m_ch[i]++;
        end else begin
          for (int k = 0; k < 35; k++) m_win[i][k] = m_win[i][k+5];
          for (int k = 0; k < 4; k++)  m_win[i][35+k] = m_stg[i][k];
          m_win[i][39] = int'(s);
          m_ch[i] = 0;
          m_total[i]++;
          if (m_frames[i] == 7) begin
            m_frames[i] = 8; m_hop[i] = 0; m_mode[i] = 1;
          end else if (m_frames[i] == 8) begin
            m_hop[i]++;
            if (m_hop[i] == m_stride[i]) begin m_hop[i] = 0; m_mode[i] = 1; end
          end else m_frames[i]++;
        end
      end
      1: begin m_mode[i] = 2; m_busy[i] = 0; end
      default: begin
`ifdef WINDOW_BUFFER_DONE_HANDSHAKE_EN
        if (d && !m_dprev[i]) m_mode[i] = 0;
`else
        m_busy[i]++;
        if (m_busy[i] == CC) m_mode[i] = 0;
`endif
      end
    endcase
    m_dprev[i] = d;
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(m_mode[i] == 0));
      chk($sformatf("d%0d_start", i), 32'(start[i]), 32'(m_mode[i] == 1));
      chk($sformatf("d%0d_frames", i), 32'(frames[i]), 32'(m_frames[i]));
      for (int k = 0; k < 40; k++)
        chk($sformatf("d%0d_data%0d", i, k), 32'(dat[i][k]), 32'(m_win[i][k]));
    end
  endtask

  task automatic tick(input bit cl, input bit v, input logic [15:0] s, input bit d);
    clr = cl; vld = v; smp = s; done = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m_step(i, cl, v, s, d);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) if (start[i]) dstarts[i]++;
    cmp_all();
  endtask

  task automatic drain(input bit v);
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < 60) begin
      tick(1'b0, v, 16'($urandom), (n % 4) == 3);
      n++;
    end
    chk("drain_bound", 32'(n < 60), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready"}, 32'(rdy[i]), 32'd1);
      chk({tag, "_start"}, 32'(start[i]), 32'd0);
      chk({tag, "_frames"}, 32'(frames[i]), 32'd0);
      for (int k = 0; k < 40; k++) chk({tag, "_data"}, 32'(dat[i][k]), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; vld = 1'b0; smp = '0; done = 1'b0;
    dstarts = '{0, 0};
    m_reset(0); m_reset(1);
    @(negedge clk); @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 40 samples valued by index: first trigger right after sample 39.
    for (int k = 0; k < 40; k++) begin
      chk("pre_trigger_start", 32'(start[0]), 32'd0);
      tick(1'b0, 1'b1, 16'(k), 1'b0);
    end
    chk("first_start", 32'(start[0]), 32'd1);
    chk("first_frames", 32'(frames[0]), 32'd8);
    for (int k = 0; k < 40; k++) chk("first_window", 32'(dat[0][k]), 32'(k));
    n = 0;
    while (!rdy[0] && n < 50) begin
      tick(1'b0, 1'b0, 16'h0, n == 3);
      n++;
    end
    chk("ready_low_cycles", 32'(n), 32'(LOW_EXP));
    chk("one_start_so_far", 32'(dstarts[0]), 32'd1);

    // One more frame with STRIDE 1 retriggers; STRIDE 3 does not.
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0);
    chk("second_start", 32'(start[0]), 32'd1);
    chk("s3_no_start", 32'(start[1]), 32'd0);
    chk("shift_old", 32'(dat[0][0]), 32'd5);
    chk("shift_mid", 32'(dat[0][34]), 32'd39);
    chk("shift_new0", 32'(dat[0][35]), 32'h0100);
    chk("shift_new4", 32'(dat[0][39]), 32'h0104);
    // Valid held high with changing data while blocked.
    drain(1'b1);

    // STRIDE 3: 70 frames after a flush -> triggers at 8, 11, ..., 68.
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    dstarts = '{0, 0};
    n = 0;
    while (m_total[1] < 70 && n < 5000) begin
      tick(1'b0, 1'b1, 16'($urandom), (cyc % 4) == 3);
      n++;
    end
    drain(1'b0);
    chk("s3_frames_total", 32'(m_total[1]), 32'd70);
    chk("s3_trigger_count", 32'(dstarts[1]), 32'd21);

    // Flush mid-frame with a simultaneous valid.
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 23; k++) tick(1'b0, 1'b1, 16'($urandom), 1'b0);
    tick(1'b1, 1'b1, 16'hBEEF, 1'b0);
    chk_reset_vals("clr");
    dstarts = '{0, 0};
    for (int k = 0; k < 39; k++) tick(1'b0, 1'b1, 16'($urandom), 1'b0);
    chk("clr_no_early_start", 32'(dstarts[0]), 32'd0);
    tick(1'b0, 1'b1, 16'($urandom), 1'b0);
    chk("clr_start_at_40", 32'(start[0]), 32'd1);

`ifdef WINDOW_BUFFER_DONE_HANDSHAKE_EN
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 16'h0, 1'b1);
    chk("done_level_holds_busy", 32'(rdy[0]), 32'd0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    chk("done_low_still_busy", 32'(rdy[0]), 32'd0);
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    chk("done_rise_exits", 32'(rdy[0]), 32'd1);
`endif
    drain(1'b0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 1500; k++)
      tick(($urandom % 100) == 0, ($urandom % 10) < 7, 16'($urandom), ($urandom % 3) == 0);

    // Async reset while BUSY.
    n = 0;
    while (!start[0] && n < 400) begin
      tick(1'b0, 1'b1, 16'($urandom), (cyc % 4) == 3);
      n++;
    end
    chk("reach_start_bound", 32'(start[0]), 32'd1);
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    chk("in_busy", 32'(rdy[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    m_reset(0); m_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 60; k++) tick(1'b0, 1'b1, 16'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
